// File: rtl/fir_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fir_ctrl
// Brief   : 4-phase FIR MAC schedule controller with a saturating sample count.
// Revision: 1.0 - initial release
// ============================================================================
module fir_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vin,
    output logic       ready,
    input  logic       clr,
    input  logic       y_rdy,
    output logic       x_clr,
    output logic       shift,
    output logic [1:0] ctrl_1,
    output logic       y_clr,
    output logic       y_en,
    output logic       valid,
    output logic       primed
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_MAC0 = 3'd2,
        S_MAC1 = 3'd3,
        S_MAC2 = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    localparam logic [3:0] C_COUNT_MAX = 4'd8;

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ready   = 1'b0;
        x_clr   = 1'b0;
        shift   = 1'b0;
        ctrl_1  = 2'd0;
        y_clr   = 1'b0;
        y_en    = 1'b0;
        valid   = 1'b0;

        // Soft clear overrides everything except INIT, which already clears.
        if (clr && (state_q != S_INIT)) begin
            x_clr   = 1'b1;
            state_d = S_IDLE;
            count_d = 4'd0;
        end else begin
            case (state_q)
                S_INIT: begin
                    x_clr   = 1'b1;
                    state_d = S_IDLE;
                end
                S_IDLE: begin
                    ready = 1'b1;
                    if (vin) begin
                        shift   = 1'b1;
                        state_d = S_MAC0;
                        if (count_q != C_COUNT_MAX) begin
                            count_d = count_q + 4'd1;
                        end
                    end
                end
                S_MAC0: begin
                    ctrl_1  = 2'd0;
                    y_clr   = 1'b1;
                    state_d = S_MAC1;
                end
                S_MAC1: begin
                    ctrl_1  = 2'd1;
                    y_en    = 1'b1;
                    state_d = S_MAC2;
                end
                S_MAC2: begin
                    ctrl_1  = 2'd2;
                    y_en    = 1'b1;
                    state_d = S_OUT;
                end
                S_OUT: begin
                    ctrl_1 = 2'd3;
                    valid  = 1'b1;
                    if (y_rdy) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_INIT;
                end
            endcase
        end
    end

    assign primed = (count_q == C_COUNT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_fir_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fir_ctrl
// Brief   : Directed self-checking bench for fir_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fir_ctrl;

    logic       clk;
    logic       rst_n;
    logic       vin;
    logic       ready;
    logic       clr;
    logic       y_rdy;
    logic       x_clr;
    logic       shift;
    logic [1:0] ctrl_1;
    logic       y_clr;
    logic       y_en;
    logic       valid;
    logic       primed;

    int tests;
    int fails;

    fir_ctrl u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .vin    (vin),
        .ready  (ready),
        .clr    (clr),
        .y_rdy  (y_rdy),
        .x_clr  (x_clr),
        .shift  (shift),
        .ctrl_1 (ctrl_1),
        .y_clr  (y_clr),
        .y_en   (y_en),
        .valid  (valid),
        .primed (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {x_clr, ready, shift, y_clr, y_en, valid, ctrl_1, primed}
    function automatic logic [8:0] ev(input logic xc, input logic rd, input logic sh,
                                      input logic yc, input logic ye, input logic vl,
                                      input logic [1:0] ct, input logic pr);
        return {xc, rd, sh, yc, ye, vl, ct, pr};
    endfunction

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        #1;
        obs = {x_clr, ready, shift, y_clr, y_en, valid, ctrl_1, primed};
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic p;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        vin   = 1'b0;
        clr   = 1'b0;
        y_rdy = 1'b1;

        chk("reset", ev(1, 0, 0, 0, 0, 0, 2'd0, 0));
        @(negedge clk);
        chk("reset_held", ev(1, 0, 0, 0, 0, 0, 2'd0, 0));
        rst_n = 1'b1;
        chk("init", ev(1, 0, 0, 0, 0, 0, 2'd0, 0));
        @(negedge clk);
        chk("idle_after_init", ev(0, 1, 0, 0, 0, 0, 2'd0, 0));

        // Back-to-back samples, vin held high: accept every 5 cycles.
        vin = 1'b1;
        for (int i = 0; i < 8; i++) begin
            p = (i == 7);
            chk($sformatf("accept%0d", i), ev(0, 1, 1, 0, 0, 0, 2'd0, 0));
            @(negedge clk);
            chk($sformatf("mac0_%0d", i), ev(0, 0, 0, 1, 0, 0, 2'd0, p));
            @(negedge clk);
            chk($sformatf("mac1_%0d", i), ev(0, 0, 0, 0, 1, 0, 2'd1, p));
            @(negedge clk);
            chk($sformatf("mac2_%0d", i), ev(0, 0, 0, 0, 1, 0, 2'd2, p));
            @(negedge clk);
            chk($sformatf("out_%0d", i), ev(0, 0, 0, 0, 0, 1, 2'd3, p));
            @(negedge clk);
        end

        // Ninth accept: count saturates, primed stays high.
        chk("accept_sat", ev(0, 1, 1, 0, 0, 0, 2'd0, 1));
        @(negedge clk);
        chk("mac0_sat", ev(0, 0, 0, 1, 0, 0, 2'd0, 1));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        // Backpressure in OUT for 3 cycles, with vin still high (ignored).
        y_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("out_hold%0d", k), ev(0, 0, 0, 0, 0, 1, 2'd3, 1));
            @(negedge clk);
        end
        y_rdy = 1'b1;
        vin   = 1'b0;
        chk("out_release", ev(0, 0, 0, 0, 0, 1, 2'd3, 1));
        @(negedge clk);
        chk("idle_after_hold", ev(0, 1, 0, 0, 0, 0, 2'd0, 1));

        // Soft clear during MAC1.
        vin = 1'b1;
        chk("accept_pre_clr", ev(0, 1, 1, 0, 0, 0, 2'd0, 1));
        @(negedge clk);
        vin = 1'b0;
        chk("mac0_pre_clr", ev(0, 0, 0, 1, 0, 0, 2'd0, 1));
        @(negedge clk);
        clr = 1'b1;
        chk("clr_in_mac1", ev(1, 0, 0, 0, 0, 0, 2'd0, 1));
        @(negedge clk);
        clr = 1'b0;
        chk("idle_after_clr", ev(0, 1, 0, 0, 0, 0, 2'd0, 0));
        @(negedge clk);
        chk("no_valid_after_clr", ev(0, 1, 0, 0, 0, 0, 2'd0, 0));

        // vin and clr together in IDLE: clear wins, no accept.
        vin = 1'b1;
        clr = 1'b1;
        chk("clr_vs_vin", ev(1, 0, 0, 0, 0, 0, 2'd0, 0));
        @(negedge clk);
        vin = 1'b0;
        clr = 1'b0;
        chk("idle_after_clr_vin", ev(0, 1, 0, 0, 0, 0, 2'd0, 0));

        // Reset dropped during OUT aborts immediately.
        vin = 1'b1;
        chk("accept_pre_rst", ev(0, 1, 1, 0, 0, 0, 2'd0, 0));
        @(negedge clk);
        vin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("out_pre_rst", ev(0, 0, 0, 0, 0, 1, 2'd3, 0));
        rst_n = 1'b0;
        chk("rst_in_out", ev(1, 0, 0, 0, 0, 0, 2'd0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        clr   = 1'b1;
        chk("init_clr_ignored", ev(1, 0, 0, 0, 0, 0, 2'd0, 0));
        @(negedge clk);
        clr = 1'b0;
        chk("idle_after_rst", ev(0, 1, 0, 0, 0, 0, 2'd0, 0));
        vin = 1'b1;
        chk("accept_after_rst", ev(0, 1, 1, 0, 0, 0, 2'd0, 0));
        @(negedge clk);
        vin = 1'b0;
        chk("mac0_after_rst", ev(0, 0, 0, 1, 0, 0, 2'd0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_ctrl.md
FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 SHALL have no parameters; the 4-phase schedule (ctrl_1 = 0..3) is fixed.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 vin  input  1  upstream sample valid; datapath input x is stable while vin=1.
REQ-005 ready  output  1  controller can accept a sample this cycle.
REQ-006 clr  input  1  synchronous soft clear of delay line and schedule.
REQ-007 y_rdy  input  1  downstream accepts the datapath output y this cycle.
REQ-008 x_clr  output  1  delay-line clear strobe to the datapath.
REQ-009 shift  output  1  delay-line shift strobe to the datapath.
REQ-010 ctrl_1  output  2  tap-pair select to the datapath.
REQ-011 y_clr  output  1  accumulator load to the datapath.
REQ-012 y_en  output  1  accumulator add to the datapath.
REQ-013 valid  output  1  datapath output y is valid; held until y_rdy.
REQ-014 primed  output  1  at least 8 samples accepted since last clear.

Function
REQ-015 States: INIT, IDLE, MAC0, MAC1, MAC2, OUT; 3-bit registered state.
REQ-016 INIT: x_clr=1, ready=0; next state IDLE unconditionally.
REQ-017 IDLE: ready=1; accept = vin & ready; on accept, shift=1 in the same cycle (Mealy), next state MAC0; otherwise stay in IDLE.
REQ-018 MAC0: ctrl_1=0, y_clr=1; next state MAC1.
REQ-019 MAC1: ctrl_1=1, y_en=1; next state MAC2.
REQ-020 MAC2: ctrl_1=2, y_en=1; next state OUT.
REQ-021 OUT: ctrl_1=3, valid=1, y_en=0, y_clr=0; if y_rdy=1, next state IDLE; else stay in OUT with all outputs held.
REQ-022 Latency: if the accept occurs in cycle T, valid SHALL be 1 from T+4; the minimum sample period is 5 cycles.
REQ-023 ctrl_1 SHALL be 0 in INIT and IDLE.
REQ-024 ready, shift, y_clr, y_en and valid SHALL be mutually exclusive strobes, with one exception: ready and shift are both 1 on an accept cycle.
REQ-025 Sample counter: 4 bits; increments on each accept; saturates at 8.
REQ-026 primed = (count == 8), decoded from a register.
REQ-027 clr=1 in any state SHALL have priority over every other input and state:
  - that cycle: x_clr=1; shift, y_clr, y_en, valid and ready = 0;
  - next state IDLE; count <= 0.
REQ-028 clr SHALL be ignored while in INIT; INIT already asserts x_clr.
REQ-029 vin=1 outside IDLE SHALL be ignored, with no shift and no count change; upstream holds the sample until ready=1.
REQ-030 Simultaneous vin=1 and clr=1 in IDLE: clr wins, and the sample is not accepted.

Reset
REQ-031 While rst_n=0:
  - state = INIT, count = 0;
  - outputs: x_clr=1, ready=0, shift=0, y_clr=0, y_en=0, valid=0, ctrl_1=0, primed=0.
REQ-032 Assertion of rst_n mid-operation SHALL abort the schedule immediately; no valid pulse SHALL follow.
REQ-033 After rst_n deasserts, exactly one INIT cycle occurs (x_clr=1), then IDLE.

Verification
REQ-034 Reset release -> one cycle with x_clr=1, then ready=1 and ctrl_1=0, with all strobes 0.
REQ-035 vin held high, y_rdy=1 -> accepts every 5 cycles; per sample the ctrl_1 sequence is 0,1,2,3; y_clr at MAC0 only; y_en at MAC1 and MAC2; valid only at ctrl_1=3.
REQ-036 Integrated with the datapath, after reset: x=127 once, then seven x=0 samples -> y = 1,7,20,30,30,20,7,1; primed rises after the 8th accept.
REQ-037 y_rdy=0 for 3 cycles in OUT -> valid, ctrl_1=3 and the y value are held for 4 cycles; ready=0 throughout; IDLE on the cycle after y_rdy=1.
REQ-038 clr pulsed during MAC1 -> x_clr=1 that cycle, no valid pulse, next state IDLE, primed=0, count=0.
REQ-039 rst_n dropped during OUT -> valid=0 immediately; after release, INIT then IDLE with count=0.
